// File: rtl/mod_counter_if.sv
// Signal bundle for mod_counter: control inputs from the master side,
// count and event flags back from the counter.
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic             sat_mode;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             sat_hit;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up, sat_mode,
    input  cnt, tc, wrap, sat_hit, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up, sat_mode,
    output cnt, tc, wrap, sat_hit, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up/down counter with clear, clamped load, wrap/saturate
// mode, a terminal-count look-ahead and wrap/saturation/overflow flags.
module mod_counter #(
  parameter int          WIDTH = 4,
  parameter logic [31:0] MAX   = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_counter_if.slave   bus
);
  localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_reg;
  logic             wrap_reg;
  logic             sat_hit_reg;
  logic             ovf_reg;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (cnt_reg == MAX_W);
  assign at_zero = (cnt_reg == '0);

  assign bus.cnt     = cnt_reg;
  assign bus.wrap    = wrap_reg;
  assign bus.sat_hit = sat_hit_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.tc      = bus.en & ~bus.clr & ~bus.load &
                       ((bus.up & at_max) | (~bus.up & at_zero));

  // Steps are only taken strictly inside 0..MAX, so the +1/-1 can never
  // leave the range even when MAX fills the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      wrap_reg    <= 1'b0;
      sat_hit_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      wrap_reg    <= 1'b0;
      sat_hit_reg <= 1'b0;
      if (bus.clr) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (bus.load) begin
        cnt_reg <= (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
      end else if (bus.en) begin
        if (bus.up) begin
          if (at_max) begin
            ovf_reg <= 1'b1;
            if (bus.sat_mode) begin
              sat_hit_reg <= 1'b1;
            end else begin
              cnt_reg  <= '0;
              wrap_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + ONE_W;
          end
        end else begin
          if (at_zero) begin
            ovf_reg <= 1'b1;
            if (bus.sat_mode) begin
              sat_hit_reg <= 1'b1;
            end else begin
              cnt_reg  <= MAX_W;
              wrap_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - ONE_W;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: two instances (MAX=9 and MAX=15, WIDTH=4) driven
// with identical stimulus and checked against an integer model via a queue.
module tb_mod_counter;
  logic clk;
  logic rst_n;

  mod_counter_if #(.WIDTH(4)) ifa ();
  mod_counter_if #(.WIDTH(4)) ifb ();

  mod_counter #(.WIDTH(4), .MAX(9))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mod_counter #(.WIDTH(4), .MAX(15)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt_a; bit wrap_a; bit sat_a; bit ovf_a; bit tc_a;
    int cnt_b; bit wrap_b; bit sat_b; bit ovf_b; bit tc_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference state: plain integers, one set per instance.
  int ma_cnt = 0, mb_cnt = 0;
  bit ma_ovf = 0, mb_ovf = 0;
  bit ma_wrap = 0, mb_wrap = 0;
  bit ma_sat = 0, mb_sat = 0;

  task automatic model_step(input int maxv, input bit c, input bit l, input int lv,
                            input bit e, input bit u, input bit s,
                            inout int cnt, inout bit ovf, output bit w, output bit sh);
    w  = 1'b0;
    sh = 1'b0;
    if (c) begin
      cnt = 0;
      ovf = 1'b0;
    end else if (l) begin
      cnt = (lv > maxv) ? maxv : lv;
    end else if (e) begin
      int nxt;
      nxt = u ? cnt + 1 : cnt - 1;
      if (nxt >= 0 && nxt <= maxv) begin
        cnt = nxt;
      end else begin
        ovf = 1'b1;
        if (s) sh = 1'b1;
        else begin
          w   = 1'b1;
          cnt = u ? 0 : maxv;
        end
      end
    end
  endtask

  function automatic bit model_tc(int maxv, int cnt, bit c, bit l, bit e, bit u);
    return e && !c && !l && ((u && cnt == maxv) || (!u && cnt == 0));
  endfunction

  // One cycle: drive inputs just after the rising edge, log what the DUTs
  // must show before the next edge, then advance the model across that edge.
  task automatic cyc(input bit r, input bit c, input bit l, input int lv,
                     input bit e, input bit u, input bit s);
    exp_t rec;
    @(posedge clk);
    #2;
    rst_n = r;
    ifa.clr = c; ifa.load = l; ifa.load_val = lv[3:0]; ifa.en = e; ifa.up = u; ifa.sat_mode = s;
    ifb.clr = c; ifb.load = l; ifb.load_val = lv[3:0]; ifb.en = e; ifb.up = u; ifb.sat_mode = s;
    if (!r) begin
      ma_cnt = 0; ma_ovf = 0; ma_wrap = 0; ma_sat = 0;
      mb_cnt = 0; mb_ovf = 0; mb_wrap = 0; mb_sat = 0;
    end
    rec.cnt_a = ma_cnt; rec.wrap_a = ma_wrap; rec.sat_a = ma_sat; rec.ovf_a = ma_ovf;
    rec.cnt_b = mb_cnt; rec.wrap_b = mb_wrap; rec.sat_b = mb_sat; rec.ovf_b = mb_ovf;
    rec.tc_a  = model_tc(9,  ma_cnt, c, l, e, u);
    rec.tc_b  = model_tc(15, mb_cnt, c, l, e, u);
    exp_q.push_back(rec);
    if (r) begin
      model_step(9,  c, l, lv, e, u, s, ma_cnt, ma_ovf, ma_wrap, ma_sat);
      model_step(15, c, l, lv, e, u, s, mb_cnt, mb_ovf, mb_wrap, mb_sat);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (txn %0d)", name, act, exp, txn);
    end
  endtask

  // Monitor: compares mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_cnt",  int'(ifa.cnt),     e.cnt_a);
        chk("a_wrap", int'(ifa.wrap),    int'(e.wrap_a));
        chk("a_sat",  int'(ifa.sat_hit), int'(e.sat_a));
        chk("a_ovf",  int'(ifa.ovf),     int'(e.ovf_a));
        chk("a_tc",   int'(ifa.tc),      int'(e.tc_a));
        chk("b_cnt",  int'(ifb.cnt),     e.cnt_b);
        chk("b_wrap", int'(ifb.wrap),    int'(e.wrap_b));
        chk("b_sat",  int'(ifb.sat_hit), int'(e.sat_b));
        chk("b_ovf",  int'(ifb.ovf),     int'(e.ovf_b));
        chk("b_tc",   int'(ifb.tc),      int'(e.tc_b));
        $display("txn %0d a: cnt=%0d tc=%0b w=%0b s=%0b o=%0b | b: cnt=%0d tc=%0b w=%0b s=%0b o=%0b",
                 txn, ifa.cnt, ifa.tc, ifa.wrap, ifa.sat_hit, ifa.ovf,
                 ifb.cnt, ifb.tc, ifb.wrap, ifb.sat_hit, ifb.ovf);
        txn++;
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    ifa.clr = 0; ifa.load = 0; ifa.load_val = '0; ifa.en = 0; ifa.up = 0; ifa.sat_mode = 0;
    ifb.clr = 0; ifb.load = 0; ifb.load_val = '0; ifb.en = 0; ifb.up = 0; ifb.sat_mode = 0;

    // Reset, then async reset mid-count at cnt=6, then resume 0,1,2.
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 6, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);

    // Up wrap over 12 edges from 0.
    cyc(1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 1, 1, 0);

    // Down saturate from 2.
    cyc(1, 0, 1, 2, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 0, 1);

    // Load clamp, load beats en, clr beats everything.
    cyc(1, 0, 1, 14, 0, 1, 0);
    cyc(1, 0, 1, 3, 1, 1, 0);
    cyc(1, 1, 1, 7, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);

    // Full-range wrap both directions.
    cyc(1, 0, 1, 15, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Idle hold at 4.
    cyc(1, 0, 1, 4, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(bit'($urandom_range(0, 99) != 0),
          bit'($urandom_range(0, 99) < 5),
          bit'($urandom_range(0, 99) < 10),
          int'($urandom_range(0, 15)),
          bit'($urandom_range(0, 99) < 75),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end
    cyc(1, 0, 0, 0, 0, 1, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter that generalises the team's fixed 4-bit free-running counter. It adds a programmable width and terminal value, direction control, enable, synchronous clear and load, wrap or saturate mode, and event flags. It sits beside the existing counter in the digital-logic block library and is used as a timebase and event counter by downstream sequencers.

## Interface
- WIDTH, 4: counter width in bits, 2 to 32.
- MAX, 15: terminal value, 1 ≤ MAX ≤ 2^WIDTH−1. The count range is 0..MAX, giving modulus MAX+1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserting it clears all state immediately; release is synchronous to clk by the integrator.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- sat_mode  input  1  1 saturates at the range ends, 0 wraps.
- cnt  output  WIDTH  current count, registered.
- tc  output  1  terminal-count look-ahead, combinational.
- wrap  output  1  one-cycle registered pulse on wrap-around.
- sat_hit  output  1  one-cycle registered pulse on a step blocked by saturation.
- ovf  output  1  sticky overflow/underflow flag, registered.

## Operation
- Per-edge priority is clr > load > en > hold.
- clr:
  - cnt ← 0, ovf ← 0, wrap ← 0, sat_hit ← 0.
- load (clr = 0):
  - cnt ← min(load_val, MAX). A load_val above MAX clamps to MAX.
  - wrap and sat_hit are 0 and ovf holds. Loading never sets a flag.
- en (clr = 0, load = 0):
  - Up with cnt < MAX: cnt ← cnt+1.
  - Up with cnt == MAX, sat_mode = 0: cnt ← 0, wrap ← 1, ovf ← 1.
  - Up with cnt == MAX, sat_mode = 1: cnt holds MAX, sat_hit ← 1, ovf ← 1.
  - Down with cnt > 0: cnt ← cnt−1.
  - Down with cnt == 0, sat_mode = 0: cnt ← MAX, wrap ← 1, ovf ← 1.
  - Down with cnt == 0, sat_mode = 1: cnt holds 0, sat_hit ← 1, ovf ← 1.
- Idle (en = 0, clr = 0, load = 0): cnt and ovf hold; wrap and sat_hit ← 0.
- tc = en & ~clr & ~load & ((up & cnt==MAX) | (~up & cnt==0)). It predicts a wrap or sat event on the next edge.
- Arithmetic:
  - Comparisons are unsigned and WIDTH bits wide.
  - cnt never leaves 0..MAX by any path, including when MAX = 2^WIDTH−1, where natural overflow must still produce exactly 0.
- up and sat_mode may change on any cycle; they take effect on the next edge.
- There is no internal state machine beyond the count register and flags. The "state" is cnt, with implicit regions ZERO, MID and MAX that select the step rule above.

## Timing
- Reset (rst_n = 0, asynchronous): cnt = 0, wrap = 0, sat_hit = 0, ovf = 0, within the same cycle and without waiting for a clk edge.
- Reset asserted mid-count clears immediately. After release, the first active edge behaves as if starting from 0.
- Latency:
  - clr, load and en affect cnt on the first rising edge at which they are sampled high, so cnt updates one cycle after the request.
  - wrap and sat_hit are high for exactly the cycle after the triggering edge, coincident with the updated cnt.
  - ovf rises on that same edge and stays high until clr or reset.
- tc is valid combinationally in the cycle before the edge that causes wrap or sat_hit.
- Simultaneous events:
  - clr with load: clr wins, cnt = 0.
  - load with en: load wins and no step occurs.
  - clr on the edge that would wrap: cnt = 0 and ovf = 0; the wrap is not reported.

## Test plan
WIDTH = 4, MAX = 9 unless noted.
- Reset: pulse rst_n low mid-cycle while cnt = 6 -> cnt, wrap, sat_hit and ovf all 0 before the next edge; counting resumes 0, 1, 2 after release.
- Up wrap: en = 1, up = 1, sat_mode = 0, 12 edges from 0 -> cnt 1..9, 0, 1, 2; tc high only while cnt = 9; wrap high one cycle with cnt = 0; ovf stays 1.
- Down saturate: load_val = 2, then en = 1, up = 0, sat_mode = 1, 4 edges -> cnt 1, 0, 0, 0; sat_hit high for exactly the cycles following the two blocked edges; wrap never asserts.
- Load clamp and priority:
  - load_val = 14 -> cnt = 9.
  - load with en on the same edge -> no increment.
  - clr, load and en all high -> cnt = 0 and ovf cleared.
- Full-range width: WIDTH = 4, MAX = 15, up from 15 -> cnt = 0 and wrap = 1; down from 0 -> cnt = 15 and wrap = 1.
- Idle hold: en = 0 for 5 edges at cnt = 4 -> cnt stays 4, wrap and sat_hit stay 0, ovf unchanged.
